// File: rtl/ethernet_pkg.sv
// Shared IPv4 constants, the handler FSM state type and a one's-complement add helper.
package ethernet_pkg;
   localparam int         IPV4_MIN_HDR_BYTES = 20;
   localparam logic [3:0] IPV4_VERSION       = 4'd4;
   localparam logic [7:0] IP_PROTO_TCP       = 8'h06;

   typedef enum logic [2:0] {IDLE, HDR, OPTS, META, FWD, DRAIN} ipv4_state_t;

   // 16-bit one's-complement add; a single end-around fold always suffices.
   function automatic logic [15:0] csum_add(input logic [15:0] a, input logic [15:0] b);
      logic [16:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[15:0] + {15'd0, s[16]};
   endfunction
endpackage

// File: rtl/axi_stream_if.sv
// Byte-stream handshake bundle with producer (master) and consumer (slave) views.
interface axi_stream_if #(parameter int DATA_WIDTH = 8);
   logic [DATA_WIDTH-1:0] tdata;
   logic                  tvalid;
   logic                  tready;
   logic                  tlast;

   modport master (output tdata, tvalid, tlast, input tready);
   modport slave  (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/ipv4_csum_acc.sv
// Byte-serial one's-complement accumulator; pairs bytes big-endian into 16-bit words.
module ipv4_csum_acc import ethernet_pkg::*; (
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        byte_vld,
   input  logic [7:0]  byte_data,
   output logic [15:0] sum
);
   logic       odd;
   logic [7:0] hi;

   // clr together with byte_vld starts a fresh sum with this byte as the high half
   always_ff @(posedge clk) begin
      if (rst) begin
         sum <= '0;
         odd <= 1'b0;
         hi  <= '0;
      end else if (byte_vld) begin
         if (clr || !odd) begin
            hi  <= byte_data;
            odd <= 1'b1;
            if (clr) sum <= '0;
         end else begin
            sum <= csum_add(sum, {hi, byte_data});
            odd <= 1'b0;
         end
      end else if (clr) begin
         sum <= '0;
         odd <= 1'b0;
      end
   end
endmodule

// File: rtl/ipv4_handler.sv
// IPv4 header parser/validator: emits metadata and forwards the L4 segment of accepted datagrams.
module ipv4_handler import ethernet_pkg::*; #(
   parameter int         DATA_WIDTH   = 8,
   parameter logic [7:0] ACCEPT_PROTO = IP_PROTO_TCP
) (
   input  logic         clk,
   input  logic         rst,
   axi_stream_if.slave  s_axis,
   axi_stream_if.master m_axis,
   output logic         meta_valid,
   input  logic         meta_ready,
   output logic [31:0]  meta_src_ip,
   output logic [31:0]  meta_dst_ip,
   output logic [7:0]   meta_protocol,
   output logic [15:0]  meta_l4_len,
   output logic [15:0]  drop_count
);
   ipv4_state_t state, next;

   logic [DATA_WIDTH-1:0] din, m_data;
   logic [5:0]  cnt, ihl4, hdr_last;
   logic [7:0]  vihl, tl_hi;
   logic [15:0] tot_len, rem, csum;
   logic [12:0] frag_off;
   logic        mf, tlast_seen, meta_pend, m_vld, m_last;
   logic        s_ready, acc, hdr_ok, drop, is_last;

   assign din      = s_axis.tdata;
   assign acc      = s_ready && s_axis.tvalid;
   assign ihl4     = {vihl[3:0], 2'b00};
   assign hdr_last = (ihl4 < 6'(IPV4_MIN_HDR_BYTES)) ? 6'(IPV4_MIN_HDR_BYTES - 1) : ihl4 - 6'd1;
   assign is_last  = (cnt == hdr_last);

   assign s_axis.tready = s_ready;
   assign m_axis.tdata  = m_data;
   assign m_axis.tvalid = m_vld;
   assign m_axis.tlast  = m_last;

   ipv4_csum_acc u_csum (
      .clk       (clk),
      .rst       (rst),
      .clr       (state == IDLE && acc),
      .byte_vld  (acc && (state == IDLE || state == HDR || state == OPTS)),
      .byte_data (din),
      .sum       (csum)
   );

   // A header whose last byte carried tlast but still owes L4 bytes counts as truncated
   always_comb begin
      hdr_ok = (vihl[7:4] == IPV4_VERSION) && (ihl4 >= 6'(IPV4_MIN_HDR_BYTES)) &&
               (tot_len >= {10'd0, ihl4}) && (meta_protocol == ACCEPT_PROTO) &&
               !mf && (frag_off == '0) && (csum == 16'hFFFF) &&
               !(tlast_seen && meta_l4_len != '0);
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= next;
   end

   always_comb begin
      next = state;
      drop = 1'b0;
      case (state)
         IDLE: if (acc) begin
            next = s_axis.tlast ? IDLE : HDR;
            drop = s_axis.tlast;
         end
         HDR: if (acc) begin
            if (is_last)                                     next = META;
            else if (s_axis.tlast)                           begin next = IDLE; drop = 1'b1; end
            else if (cnt == 6'(IPV4_MIN_HDR_BYTES - 1))      next = OPTS;
         end
         OPTS: if (acc) begin
            if (is_last)           next = META;
            else if (s_axis.tlast) begin next = IDLE; drop = 1'b1; end
         end
         META: begin
            if (hdr_ok) next = (meta_l4_len != '0) ? FWD : (tlast_seen ? IDLE : DRAIN);
            else begin
               drop = 1'b1;
               next = tlast_seen ? IDLE : DRAIN;
            end
         end
         FWD: if (acc) begin
            if (rem == 16'd1)      next = s_axis.tlast ? IDLE : DRAIN;
            else if (s_axis.tlast) begin next = IDLE; drop = 1'b1; end
         end
         DRAIN: if (acc && s_axis.tlast) next = IDLE;
         default: next = IDLE;
      endcase
   end

   always_comb begin
      s_ready    = 1'b0;
      meta_valid = meta_pend || (state == META && hdr_ok);
      case (state)
         IDLE:             s_ready = !meta_pend || meta_ready;
         HDR, OPTS, DRAIN: s_ready = 1'b1;
         FWD:              s_ready = !m_vld || m_axis.tready;
         default:          s_ready = 1'b0;
      endcase
      if (rst) s_ready = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0; vihl <= '0; tl_hi <= '0; tot_len <= '0; mf <= 1'b0; frag_off <= '0;
         tlast_seen <= 1'b0; meta_pend <= 1'b0; rem <= '0;
         meta_src_ip <= '0; meta_dst_ip <= '0; meta_protocol <= '0; meta_l4_len <= '0;
         drop_count <= '0; m_data <= '0; m_vld <= 1'b0; m_last <= 1'b0;
      end else begin
         if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;

         if (state == META && hdr_ok && !meta_ready) meta_pend <= 1'b1;
         else if (meta_ready)                        meta_pend <= 1'b0;

         if (m_vld && m_axis.tready) m_vld <= 1'b0;

         case (state)
            IDLE: if (acc) begin
               vihl       <= din;
               cnt        <= 6'd1;
               tlast_seen <= 1'b0;
            end
            HDR, OPTS: if (acc) begin
               cnt        <= cnt + 6'd1;
               tlast_seen <= s_axis.tlast;
               case (cnt)
                  6'd2: tl_hi <= din;
                  6'd3: begin
                     tot_len     <= {tl_hi, din};
                     meta_l4_len <= {tl_hi, din} - {10'd0, ihl4};
                  end
                  6'd6: begin mf <= din[5]; frag_off[12:8] <= din[4:0]; end
                  6'd7: frag_off[7:0] <= din;
                  6'd9: meta_protocol <= din;
                  6'd12, 6'd13, 6'd14, 6'd15: meta_src_ip <= {meta_src_ip[23:0], din};
                  6'd16, 6'd17, 6'd18, 6'd19: meta_dst_ip <= {meta_dst_ip[23:0], din};
                  default: ;
               endcase
            end
            META: rem <= meta_l4_len;
            FWD: if (acc) begin
               m_data <= din;
               m_vld  <= 1'b1;
               m_last <= (rem == 16'd1) || s_axis.tlast;
               rem    <= rem - 16'd1;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: doc/ipv4_handler.md
IPV4_HANDLER -- requirements
Module: ipv4_handler

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, byte-wide stream data width; only 8 is supported.
REQ-002 SHALL have parameter ACCEPT_PROTO, default 8'h06, IPv4 protocol number forwarded (TCP).
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 s_axis  axi_stream_if slave  8  IPv4 datagram bytes (tdata/tvalid/tready/tlast), header first.
REQ-007 m_axis  axi_stream_if master  8  L4 segment bytes (TCP header+payload) for tcp_handler.
REQ-008 meta_valid/meta_ready  output/input  1/1  metadata handshake.
REQ-009 meta_src_ip, meta_dst_ip  output  32  source and destination address.
REQ-010 meta_protocol  output  8  protocol field.
REQ-011 meta_l4_len  output  16  total_length minus IHL*4.
REQ-012 drop_count  output  16  dropped-datagram counter, saturating at 16'hFFFF.

Function
REQ-013 FSM states SHALL be IDLE, HDR, OPTS, META, FWD, DRAIN.
- IDLE -> HDR on first accepted byte.
- HDR captures bytes 0..19.
- OPTS skips bytes 20..IHL*4-1.
- META waits for the checksum verdict.
- FWD forwards L4 bytes.
- DRAIN discards bytes until s_axis tlast.
REQ-014 Fields SHALL be big-endian: version/IHL byte 0, total_length 2-3, flags/frag_offset 6-7, protocol 9, checksum 10-11, src 12-15, dst 16-19.
REQ-015 Header checksum SHALL be a 16-bit one's-complement sum over all IHL*4 header bytes, end-around carry folded every add; the header is valid only if the final sum equals 16'hFFFF.
REQ-016 A datagram SHALL be dropped if any of these holds:
- version != 4
- IHL < 5
- total_length < IHL*4
- protocol != ACCEPT_PROTO
- MF set or frag_offset != 0
- checksum invalid
- tlast arrives before byte IHL*4.
REQ-017 A dropped datagram SHALL produce no meta_valid and no m_axis beat, increment drop_count once, and go to DRAIN (or IDLE if tlast was already seen).
REQ-018 On a valid header, meta_valid SHALL rise the cycle after the last header byte is accepted, with all meta fields stable until the meta_valid && meta_ready cycle.
REQ-019 FWD SHALL forward exactly meta_l4_len bytes in order, m_axis tlast on the last byte, with one register stage (1-cycle latency).
REQ-020 s_axis.tready in FWD SHALL equal (!m_axis.tvalid || m_axis.tready); there is no bubble under continuous flow.
REQ-021 Bytes after the L4 length (Ethernet padding) SHALL be discarded in DRAIN with no drop_count increment.
REQ-022 If s_axis tlast arrives before meta_l4_len bytes, that byte SHALL be forwarded with m_axis tlast, drop_count SHALL increment, and the FSM SHALL return to IDLE.
REQ-023 If meta_l4_len == 0, the FSM SHALL skip FWD and emit no m_axis beat.
REQ-024 In IDLE, s_axis.tready SHALL be low while meta_valid of the previous datagram is unconsumed; metadata never overwrites unconsumed metadata.
REQ-025 s_axis.tready SHALL be 1 in HDR, OPTS and DRAIN; it SHALL be 0 in META.
REQ-026 Simultaneous meta handshake and a new-datagram first byte SHALL both complete in the same cycle.

Reset
REQ-027 On rst, the FSM SHALL be IDLE, and s_axis.tready, m_axis.tvalid, m_axis.tlast, m_axis.tdata, meta_valid, all meta fields and drop_count SHALL be 0.
REQ-028 Reset mid-datagram SHALL abandon it without counting; the first byte accepted after reset is treated as byte 0 of a new datagram.

Structure
REQ-029 Package ethernet_pkg SHALL hold the IPV4_MIN_HDR_BYTES=20, IPV4_VERSION=4 and IP_PROTO_TCP=8'h06 constants and the ipv4_state_t enum.
REQ-030 The one's-complement accumulator SHALL be sub-module ipv4_csum_acc: clear, byte-valid and byte-data inputs, 16-bit sum output; it handles even/odd byte pairing internally.

Verification
REQ-031 The bench SHALL cover these directed scenarios:
- Valid 20-byte header, total_length 60, protocol 6, 40 L4 bytes -> meta_l4_len 40, src/dst match, 40 m_axis bytes with tlast on the 40th, drop_count 0.
- Same datagram with one checksum bit flipped -> no meta_valid, no m_axis beats, drop_count 1.
- IHL 6 (4 option bytes), total_length 44 -> option bytes skipped, meta_l4_len 20, 20 bytes forwarded.
- total_length 46 inside a 60-byte frame (14 pad bytes) -> 26 bytes forwarded, pad discarded, drop_count unchanged.
- Two back-to-back valid datagrams with meta_ready held 0 for 50 cycles -> second header stalled (s_axis.tready 0), both metadata sets delivered in order after meta_ready rises.
- Protocol 17 (UDP) followed by a valid TCP datagram -> first dropped (drop_count 1), second forwarded intact.
